// File: rtl/sync_ram_dp.sv
// sync_ram_dp: simple-dual-port synchronous RAM with byte-lane writes,
// selectable read-during-write behaviour, optional output register and a
// clear sequencer that fills every word with CLEAR_VALUE after reset.
module sync_ram_dp #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    OUT_REG     = 0,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      init_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clr_last;
  logic                    clr_we;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rd_hit;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_data_p0;
  logic                    vld_p0;

  // Replace the byte lanes selected by be with the matching lanes of new_w.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [LANES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign clr_last  = (clr_cnt == {ADDR_WIDTH{1'b1}});
  assign clr_we    = (state == CLEAR) && !rst;
  // Writes landing on the reset edge are dropped: the array is about to be re-cleared.
  assign wr_fire   = (state == READY) && !rst && wr_en && (|wr_be);
  assign rd_fire   = (state == READY) && rd_en;
  assign rd_hit    = wr_fire && (wr_addr == rd_addr);
  assign init_busy = (state == CLEAR);

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Sequencer next state: leave CLEAR right after the last address is written.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Clear address counter; holds at 0 while rst is high.
  always_ff @(posedge clk) begin
    if (rst)         clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  end

  // Array write port: clear sweep has priority, user writes are per byte lane.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (wr_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read word selection; write-first mode forwards the merged word on an address hit.
  always_comb begin
    rd_word = mem[rd_addr];
    if ((RDW_MODE != 0) && rd_hit) rd_word = merge_lanes(mem[rd_addr], wr_data, wr_be);
  end

  // ---- stage p0: array read register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) rd_data_p0 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // ---- stage p1: optional output register ----
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rd_data_p1 <= rd_data_p0;
        end
      end

      assign rd_data  = rd_data_p1;
      assign rd_valid = vld_p1;
    end else begin : g_no_out_reg
      assign rd_data  = rd_data_p0;
      assign rd_valid = vld_p0;
    end
  endgenerate

endmodule
